// File: rtl/regfile_32x64_core.sv
// Architectural register file: 31 writable WIDTH-bit registers plus a hardwired-zero
// register, with same-cycle write-to-read bypass on both read ports.
module regfile_32x64_core #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    RegWrite,
    input  logic [4:0]              WriteRegister,
    input  logic [WIDTH-1:0]        WriteData,
    input  logic [4:0]              ReadRegister1,
    input  logic [4:0]              ReadRegister2,
    output logic [WIDTH-1:0]        ReadData1,
    output logic [WIDTH-1:0]        ReadData2,
    output logic [31:0][WIDTH-1:0]  regs_out
);

    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

    logic [31:0] en_s;

    // Read-port select: zero register, then bypass from WB, then committed state.
    function automatic logic [WIDTH-1:0] read_port(
        input logic                   rst_ok,
        input logic [4:0]             idx,
        input logic                   we,
        input logic [4:0]             widx,
        input logic [WIDTH-1:0]       wdata,
        input logic [31:0][WIDTH-1:0] regs
    );
        logic [WIDTH-1:0] res;
        if (!rst_ok) begin
            res = {WIDTH{1'b0}};
        end else if (idx == ZERO_IDX) begin
            res = {WIDTH{1'b0}};
        end else if (we && (widx == idx)) begin
            res = wdata;
        end else begin
            res = regs[idx];
        end
        return res;
    endfunction

    // Write decoder: one-hot enable, never for the zero register.
    always_comb begin
        en_s = 32'h0000_0000;
        for (int i = 0; i < 32; i++) begin
            if (RegWrite && (WriteRegister == 5'(i)) && (i != ZERO_REG)) begin
                en_s[i] = 1'b1;
            end else begin
                en_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_reg
        if (g == ZERO_REG) begin : g_zero
            assign regs_out[g] = {WIDTH{1'b0}};
        end else begin : g_flop
            logic [WIDTH-1:0] q_r;

            // Enabled storage flop for one architectural register.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q_r <= {WIDTH{1'b0}};
                end else if (en_s[g]) begin
                    q_r <= WriteData;
                end else begin
                    q_r <= q_r;
                end
            end

            assign regs_out[g] = q_r;
        end
    end

    // Zero-latency read ports; forced to zero while reset is held.
    always_comb begin
        ReadData1 = read_port(reset, ReadRegister1, RegWrite, WriteRegister, WriteData, regs_out);
        ReadData2 = read_port(reset, ReadRegister2, RegWrite, WriteRegister, WriteData, regs_out);
    end

endmodule

// File: tb/tb_regfile_32x64_core.sv
// Self-checking bench for regfile_32x64_core: directed scenarios plus random traffic
// compared against an array-based register model.
module tb_regfile_32x64_core;

    logic                   clk;
    logic                   reset;
    logic                   RegWrite;
    logic [4:0]             WriteRegister;
    logic [63:0]            WriteData;
    logic [4:0]             ReadRegister1;
    logic [4:0]             ReadRegister2;
    logic [63:0]            ReadData1;
    logic [63:0]            ReadData2;
    logic [31:0][63:0]      regs_out;

    logic [63:0] model [32];
    int n_cmp;
    int n_err;

    regfile_32x64_core #(.WIDTH(64), .ZERO_REG(31)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .regs_out      (regs_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] exp_read(input logic [4:0] idx);
        if (!reset) return 64'h0;
        if (idx == 5'd31) return 64'h0;
        if (RegWrite && (WriteRegister == idx)) return WriteData;
        return model[idx];
    endfunction

    task automatic check_reads(input string tag);
        logic [63:0] e1;
        logic [63:0] e2;
        e1 = exp_read(ReadRegister1);
        e2 = exp_read(ReadRegister2);
        n_cmp++;
        assert (ReadData1 === e1) else begin
            n_err++;
            $error("FAIL %s rd1 observed=%h expected=%h", tag, ReadData1, e1);
        end
        n_cmp++;
        assert (ReadData2 === e2) else begin
            n_err++;
            $error("FAIL %s rd2 observed=%h expected=%h", tag, ReadData2, e2);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            assert (regs_out[i] === model[i]) else begin
                n_err++;
                $error("FAIL %s regs_out[%0d] observed=%h expected=%h", tag, i, regs_out[i], model[i]);
            end
        end
    endtask

    task automatic apply(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2, input string tag);
        @(negedge clk);
        RegWrite      = we;
        WriteRegister = wr;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        #1;
        check_reads(tag);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (reset && RegWrite && (WriteRegister != 5'd31)) begin
            model[WriteRegister] = WriteData;
        end
        #1;
        check_regs(tag);
        check_reads(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        reset = 1'b1;
        RegWrite = 1'b0;
        WriteRegister = 5'd0;
        WriteData = 64'h0;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        #1 reset = 1'b0;

        // Writes ignored while reset is held
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd5, 5'd31, "rst_hold");
            tick("rst_hold_edge");
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reads("rst_release_bypass");
        tick("rst_release_write");

        // Fill and sweep
        for (int i = 0; i < 31; i++) begin
            apply(1'b1, 5'(i), (64'(i) << 40) | (64'($urandom) << 8) | 64'(i), 5'(i), 5'(30 - i), "fill");
            tick("fill_edge");
        end
        for (int i = 0; i < 32; i++) begin
            apply(1'b0, 5'(i), 64'h0, 5'(i), 5'(31 - i), "sweep");
        end

        // Zero register write
        apply(1'b1, 5'd31, '1, 5'd31, 5'd31, "zero_wr");
        tick("zero_wr_edge");

        // Bypass
        apply(1'b1, 5'd7, 64'h1111, 5'd3, 5'd4, "byp_setup");
        tick("byp_setup_edge");
        apply(1'b0, 5'd7, 64'h2222, 5'd7, 5'd8, "byp_off");
        apply(1'b1, 5'd7, 64'h2222, 5'd7, 5'd8, "byp_on");
        tick("byp_edge");
        apply(1'b1, 5'd9, 64'hA5A5_5A5A_0F0F_F0F0, 5'd9, 5'd9, "byp_both");
        tick("byp_both_edge");

        // Random traffic against the model
        for (int k = 0; k < 300; k++) begin
            apply(1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom},
                  5'($urandom), 5'($urandom), "rand");
            tick("rand_edge");
        end

        // Write gating
        for (int k = 0; k < 10; k++) begin
            apply(1'b0, 5'(k * 3), {$urandom, $urandom}, 5'(k), 5'(k * 3), "gate");
            tick("gate_edge");
        end

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        #1;
        check_regs("async_rst");
        check_reads("async_rst");
        #1;
        reset = 1'b1;
        apply(1'b0, 5'd0, 64'h0, 5'd7, 5'd9, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
